dm_be: RTL



---
 rtl/dm_be_pkg.sv | 24 ++
 rtl/dm_be_be_gen.sv | 40 ++++
 rtl/dm_be.sv | 65 ++++++
 3 files changed

// File: rtl/dm_be_pkg.sv
// rtl/dm_be_pkg.sv - shared MEM-stage opcode constants and load/store classifiers
package dm_be_pkg;

  typedef enum logic [5:0] {
    OP_LB  = 6'b100000,
    OP_LH  = 6'b100001,
    OP_LW  = 6'b100011,
    OP_LBU = 6'b100100,
    OP_LHU = 6'b100101,
    OP_SB  = 6'b101000,
    OP_SH  = 6'b101001,
    OP_SW  = 6'b101011
  } opcode_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/dm_be_be_gen.sv
// rtl/dm_be_be_gen.sv - byte-enable, store-lane and alignment decode for data memory
module be_gen
  import dm_be_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic        misaligned
);

  always_comb begin
    be         = 4'b0000;
    lane_data  = wd;
    misaligned = 1'b0;
    case (op)
      OP_SB: begin
        be        = 4'b0001 << addr_lo;
        lane_data = {4{wd[7:0]}};
      end
      OP_SH: begin
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{wd[15:0]}};
      end
      OP_SW: begin
        misaligned = |addr_lo;
        be         = 4'b1111;
      end
      OP_LH, OP_LHU: misaligned = addr_lo[0];
      OP_LW:         misaligned = |addr_lo;
      default: ;
    endcase
    // A suppressed store must not touch any lane.
    if (!we || misaligned) be = 4'b0000;
  end

endmodule

// File: rtl/dm_be.sv
// rtl/dm_be.sv - word-organised data memory with byte-enable stores and address error flags
module dm_be
  import dm_be_pkg::*;
#(
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [31:0] IR_M,
  output logic [31:0] RD,
  output logic [3:0]  BE,
  output logic        AdEL,
  output logic        AdES
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

  logic [31:0]       mem [DEPTH];
  logic [5:0]        op;
  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        lane_be;
  logic [31:0]       lane_data;
  logic              misaligned;
  logic              unused_ir;

  assign op        = IR_M[31:26];
  assign unused_ir = ^IR_M[25:0];

  // 33-bit compare so an offset near 2**32 cannot wrap into range.
  assign off      = A - BASE;
  assign in_range = {1'b0, off} < LIMIT;
  assign idx      = off[ADDR_W+1:2];

  be_gen u_be_gen (
    .op         (op),
    .addr_lo    (A[1:0]),
    .wd         (WD),
    .we         (WE),
    .be         (lane_be),
    .lane_data  (lane_data),
    .misaligned (misaligned)
  );

  assign BE   = in_range ? lane_be : 4'b0000;
  assign RD   = in_range ? mem[idx] : 32'h0;
  assign AdES = WE && is_store(op) && (misaligned || !in_range);
  assign AdEL = is_load(op) && (misaligned || !in_range);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (BE[k]) mem[idx][8*k +: 8] <= lane_data[8*k +: 8];
    end
  end

endmodule
